load_store_unit: RTL

Processor-side initiator for the data memory. It accepts one load or store request at a time from the execute/memory stage and drives the memory's address, read strobe, write strobe and write-data lines. It waits a fixed access latency, then returns aligned, sign- or zero-extended load data. The memory has no byte enables, so byte and halfword stores are performed as a read-modify-write.

---
 rtl/load_store_unit_if.sv | 35 +++
 rtl/load_store_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus bundle for load_store_unit.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// the requester holds req_valid and the req_* fields stable until that edge,
// and resp_valid is a single-cycle pulse with no back-pressure.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        misaligned;
    logic [31:0] MemoryAddress;
    logic        memRD;
    logic        memWD;
    logic [31:0] DataIn;
    logic [31:0] DataOut;

    // The unit itself
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, DataOut,
        output req_ready, resp_valid, resp_rdata, misaligned,
               MemoryAddress, memRD, memWD, DataIn
    );

    // Requester plus memory side
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, DataOut,
        input  req_ready, resp_valid, resp_rdata, misaligned,
               MemoryAddress, memRD, memWD, DataIn
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store initiator for a data memory without byte enables.
// Loads return lane-extracted, sign/zero-extended data; byte and half stores
// are done as read-modify-write. Bus outputs decode from registered state only.
module load_store_unit #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               Reset,
    load_store_unit_if.slave   bus,
    output logic [1:0]         o_dbg_state
);
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_t;

    localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr;
    logic [1:0]    r_size;
    logic          r_signed;
    logic          r_we;
    logic [15:0]   r_wdata;
    logic          r_mis;
    logic [31:0]   r_word;
    logic [31:0]   r_rdata;

    logic          w_accept;
    logic          w_req_mis;
    logic          w_cnt_zero;
    logic [7:0]    w_lane_byte;
    logic [15:0]   w_lane_half;
    logic [31:0]   w_load_data;
    logic [31:0]   w_rmw_word;

    assign w_accept   = bus.req_valid && (r_state == ST_IDLE);
    assign w_cnt_zero = (r_cnt == '0);

    // Alignment check on the incoming request fields
    always_comb begin
        w_req_mis = 1'b0;
        case (bus.req_size)
            2'b00:   w_req_mis = 1'b0;
            2'b01:   w_req_mis = bus.req_addr[0];
            2'b10:   w_req_mis = (bus.req_addr[1:0] != 2'b00);
            default: w_req_mis = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; word stores skip the read phase
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_req_mis)                              w_next = ST_RESP;
                    else if (bus.req_we && bus.req_size == 2'b10) w_next = ST_WRITE;
                    else                                        w_next = ST_READ;
                end
            end
            ST_READ:  if (w_cnt_zero) w_next = r_we ? ST_WRITE : ST_RESP;
            ST_WRITE: if (w_cnt_zero) w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Lane extraction for loads and lane merge for read-modify-write
    always_comb begin
        w_lane_byte = bus.DataOut[7:0];
        w_rmw_word  = bus.DataOut;
        case (r_addr[1:0])
            2'b00: begin w_lane_byte = bus.DataOut[7:0];   w_rmw_word[7:0]   = r_wdata[7:0]; end
            2'b01: begin w_lane_byte = bus.DataOut[15:8];  w_rmw_word[15:8]  = r_wdata[7:0]; end
            2'b10: begin w_lane_byte = bus.DataOut[23:16]; w_rmw_word[23:16] = r_wdata[7:0]; end
            default: begin w_lane_byte = bus.DataOut[31:24]; w_rmw_word[31:24] = r_wdata[7:0]; end
        endcase
        w_lane_half = r_addr[1] ? bus.DataOut[31:16] : bus.DataOut[15:0];
        w_load_data = bus.DataOut;
        if (r_size == 2'b00) begin
            w_load_data = {{24{r_signed & w_lane_byte[7]}}, w_lane_byte};
        end else if (r_size == 2'b01) begin
            w_load_data = {{16{r_signed & w_lane_half[15]}}, w_lane_half};
            w_rmw_word  = bus.DataOut;
            if (r_addr[1]) w_rmw_word[31:16] = r_wdata;
            else           w_rmw_word[15:0]  = r_wdata;
        end
    end

    // Request capture, phase counter, merged write word and load result
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt    <= '0;
            r_addr   <= '0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_mis    <= 1'b0;
            r_word   <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= bus.req_addr;
                        r_size   <= bus.req_size;
                        r_signed <= bus.req_signed;
                        r_we     <= bus.req_we;
                        r_wdata  <= bus.req_wdata[15:0];
                        r_mis    <= w_req_mis;
                        r_word   <= bus.req_wdata;
                        r_rdata  <= '0;
                        r_cnt    <= w_req_mis ? '0 : CNT_INIT;
                    end
                end
                ST_READ: begin
                    if (w_cnt_zero) begin
                        if (r_we) begin
                            r_word <= w_rmw_word;
                            r_cnt  <= CNT_INIT;
                        end else begin
                            r_rdata <= w_load_data;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WRITE: if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.req_ready     = (r_state == ST_IDLE);
    assign bus.resp_valid    = (r_state == ST_RESP);
    assign bus.misaligned    = (r_state == ST_RESP) && r_mis;
    assign bus.resp_rdata    = r_rdata;
    assign bus.memRD         = (r_state == ST_READ);
    assign bus.memWD         = (r_state == ST_WRITE);
    assign bus.MemoryAddress = (r_state == ST_READ || r_state == ST_WRITE) ? {r_addr[31:2], 2'b00} : 32'h0;
    assign bus.DataIn        = (r_state == ST_WRITE) ? r_word : 32'h0;
    assign o_dbg_state       = r_state;
endmodule
